// File: rtl/alu_mul_seq.sv
// Purpose : iterative 32x32 -> 64-bit multiplier that borrows an external ALU as its only adder.
// Latency : start accepted at edge 0, 32 add-and-shift cycles, done pulses in cycle 33, idle in cycle 34.
// Backpres: none; start is only sampled while idle and is dropped (not queued) while busy.
//
// Optional feature: define MUL_SIGNED_EN to add signed (radix-2 Booth) multiplication,
// selected per operation with is_signed. Without it every multiply is unsigned.
//
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   start, src1, src2   : request, multiplicand M, multiplier Q (sampled when idle)
//   is_signed           : signed (Booth) mode request, honoured only with MUL_SIGNED_EN
//   busy, done          : busy from cycle after accept through done; done is a 1-cycle pulse
//   product_hi/lo       : live view of the product registers, final while done, held while idle
//   alu_src1/2, alu_ctrl, alu_bonus : operand/control outputs to the shared ALU
//   alu_result, alu_cout, alu_overflow : ALU responses consumed in the same cycle

module alu_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        is_signed,
    output logic        busy,
    output logic        done,
    output logic [31:0] product_hi,
    output logic [31:0] product_lo,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [3:0]  alu_ctrl,
    output logic [2:0]  alu_bonus,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_overflow
);

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [2:0] ALU_BONUS = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic [31:0] m;
    logic        q_1;
    logic        mode;
    logic [5:0]  cnt;
    logic        busy_q;
    logic        done_q;
    logic        shift_in;

    // ------------------------------------------------------------------
    // ALU operand / control selection. Only RUN talks to the ALU; in every
    // other state the ALU sees 0 + 0 so its outputs stay quiet.
    // ------------------------------------------------------------------
    always_comb begin
        alu_src1 = '0;
        alu_src2 = '0;
        alu_ctrl = ALU_ADD;
        if (state == S_RUN) begin
            alu_src1 = p_hi;
`ifdef MUL_SIGNED_EN
            if (mode) begin
                // Booth recoding on the current LSB and the bit shifted out last step:
                // 01 ends a run of ones (add M), 10 begins one (subtract M).
                case ({p_lo[0], q_1})
                    2'b01: begin
                        alu_src2 = m;
                        alu_ctrl = ALU_ADD;
                    end
                    2'b10: begin
                        alu_src2 = m;
                        alu_ctrl = ALU_SUB;
                    end
                    default: begin
                        alu_src2 = '0;
                        alu_ctrl = ALU_ADD;
                    end
                endcase
            end else begin
                alu_src2 = p_lo[0] ? m : '0;
            end
`else
            alu_src2 = p_lo[0] ? m : '0;
`endif
        end
    end

    assign alu_bonus = ALU_BONUS;

    // ------------------------------------------------------------------
    // Bit shifted into P_hi[31]. Unsigned: the 33rd bit of the sum is the
    // carry-out. Signed: the 33-bit two's-complement sum's sign is the
    // result MSB corrected by overflow; this is what keeps M = 0x80000000
    // (where M and -M collide in 32 bits) exact.
    // ------------------------------------------------------------------
    always_comb begin
`ifdef MUL_SIGNED_EN
        shift_in = mode ? (alu_result[31] ^ alu_overflow) : alu_cout;
`else
        shift_in = alu_cout;
`endif
    end

`ifndef MUL_SIGNED_EN
    // Signed-mode inputs and the mode flop have no consumers in this build.
    logic unused_signed_path;
    assign unused_signed_path = ^{is_signed, alu_overflow, mode};
`endif

    // ------------------------------------------------------------------
    // Control and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            p_hi   <= '0;
            p_lo   <= '0;
            m      <= '0;
            q_1    <= 1'b0;
            mode   <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        p_hi   <= '0;
                        p_lo   <= src2;
                        m      <= src1;
                        q_1    <= 1'b0;
                        cnt    <= '0;
`ifdef MUL_SIGNED_EN
                        mode   <= is_signed;
`else
                        mode   <= 1'b0;
`endif
                        busy_q <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // {P_hi, P_lo, q_1} <= {t, alu_result, P_lo}: one-bit right shift
                    // of the accumulator with the fresh sum dropped into the top half.
                    p_hi <= {shift_in, alu_result[31:1]};
                    p_lo <= {alu_result[0], p_lo[31:1]};
                    q_1  <= p_lo[0];
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product_hi = p_hi;
    assign product_lo = p_lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Purpose : self-checking bench for alu_mul_seq with a behavioural 32-bit ALU attached.
// Latency : checks cycle-exact busy/done timing around each multiply.
// Backpres: exercises start re-pulses while busy and start held high through done.

module tb_alu_mul_seq;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
`ifdef MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        is_signed;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_ctrl;
    logic [2:0]  alu_bonus;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_overflow;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .src1         (src1),
        .src2         (src2),
        .is_signed    (is_signed),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_ctrl     (alu_ctrl),
        .alu_bonus    (alu_bonus),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow)
    );

    // Behavioural combinational ALU (add / sub with carry and signed overflow).
    logic [32:0] alu_sum;
    logic [31:0] alu_b_eff;
    always_comb begin
        alu_b_eff = (alu_ctrl == ALU_SUB) ? ~alu_src2 : alu_src2;
        alu_sum   = {1'b0, alu_src1} + {1'b0, alu_b_eff} + ((alu_ctrl == ALU_SUB) ? 33'd1 : 33'd0);
        alu_result   = alu_sum[31:0];
        alu_cout     = alu_sum[32];
        alu_overflow = (alu_src1[31] == alu_b_eff[31]) && (alu_sum[31] != alu_src1[31]);
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic product.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] r;
        if (s && SIGNED_EN) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            r  = sa * sb;
        end else begin
            r = {32'b0, a} * {32'b0, b};
        end
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'h7FFF_FFFF;
            4:       v = 32'h0000_0001;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got product 0x%08h%08h with no request outstanding",
                         product_hi, product_lo);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("product", {product_hi, product_lo}, mon_exp);
            end
        end
    end

    // Issue one multiply from a negedge in IDLE; returns at the negedge of cycle 34
    // (or just after an abort). repulse_at / abort_at are cycle numbers, 0 = none.
    task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int repulse_at, input int abort_at, input bit keep_start);
        logic [63:0] e;
        e         = ref_mul(a, b, s);
        start     = 1'b1;
        src1      = a;
        src2      = b;
        is_signed = s;
        @(posedge clk);
        exp_q.push_back(e);
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chkb("abort_busy", busy, 1'b0);
                chkb("abort_done", done, 1'b0);
                chk("abort_product", {product_hi, product_lo}, 64'd0);
                void'(exp_q.pop_back());
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chkb("post_abort_busy", busy, 1'b0);
                return;
            end
            chkb("busy_timing", busy, (cyc <= 33));
            chkb("done_timing", done, (cyc == 33));
            if (cyc <= 32) begin
                chk("alu_src1_run", 64'(alu_src1), 64'(product_hi));
                if (!(s && SIGNED_EN))
                    chk("alu_ctrl_unsigned", 64'(alu_ctrl), 64'(ALU_ADD));
            end else begin
                chk("alu_src1_idle", 64'(alu_src1), 64'd0);
                chk("alu_src2_idle", 64'(alu_src2), 64'd0);
                chk("alu_ctrl_idle", 64'(alu_ctrl), 64'(ALU_ADD));
            end
            if (cyc == 34)
                chk("product_held", {product_hi, product_lo}, e);
            if (!keep_start) begin
                start = (cyc == repulse_at);
                if (cyc == repulse_at) begin
                    src1      = $urandom;
                    src2      = $urandom;
                    is_signed = ~s;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;

        rst_n     = 1'b0;
        start     = 1'b0;
        src1      = '0;
        src2      = '0;
        is_signed = 1'b0;
        repeat (2) @(negedge clk);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chk("rst_product", {product_hi, product_lo}, 64'd0);
        chk("rst_alu_src1", 64'(alu_src1), 64'd0);
        chk("rst_alu_src2", 64'(alu_src2), 64'd0);
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(ALU_ADD));
        chk("rst_alu_bonus", 64'(alu_bonus), 64'd7);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        mul_op(32'd3, 32'd5, 1'b0, 0, 0, 1'b0);
        chk("dir_3x5", {product_hi, product_lo}, 64'h0000_0000_0000_000F);
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0);
        chk("dir_ff_u", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0);
        chk("dir_ff_s", {product_hi, product_lo},
            SIGNED_EN ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001);
        mul_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 1'b0);
        chk("dir_min_sq", {product_hi, product_lo}, 64'h4000_0000_0000_0000);
        mul_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 0, 1'b0);
        chk("dir_min_x1", {product_hi, product_lo},
            SIGNED_EN ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000);
        mul_op(32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        mul_op(32'h1234_5678, 32'd0, 1'b1, 0, 0, 1'b0);

        // Start re-pulse while busy is ignored; product then held while idle.
        mul_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 10, 0, 1'b0);
        e = ref_mul(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chkb("idle_busy", busy, 1'b0);
            chk("idle_hold", {product_hi, product_lo}, e);
        end

        // Start held high through DONE is taken on the first idle cycle.
        mul_op(32'd11, 32'd13, 1'b0, 0, 0, 1'b1);
        mul_op(32'd17, 32'd19, 1'b0, 0, 0, 1'b0);

        // Reset in cycle 15 aborts; a fresh run follows.
        mul_op(32'hABCD_EF01, 32'h0000_0055, 1'b0, 0, 15, 1'b0);
        mul_op(32'd7, 32'd6, 1'b0, 0, 0, 1'b0);
        chk("post_reset_7x6", 64'(product_lo), 64'h0000_002A);

        // Randomized operands and modes, with occasional back-to-back starts.
        for (int i = 0; i < 24; i++) begin
            a = pick_operand();
            b = pick_operand();
            mul_op(a, b, 1'($urandom_range(0, 1)), 0, 0, (i % 5 == 2) && (i < 23));
        end

        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
